// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron fed by the MAC output; 1-cycle latency on every output.
// No backpressure: cur is consumed every cycle, and is dropped while refractory.
module lif_neuron #(
  parameter logic [15:0] THRESH     = 16'd1000,
  parameter int          LEAK_SHIFT = 4,
  parameter int          REFRACT    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cur_valid,
  input  logic [15:0] cur,
  input  logic        step,
  output logic        spike,
  output logic [15:0] vmem,
  output logic        refr,
  output logic [7:0]  spike_count
);

  typedef enum logic {ST_INTEG, ST_REFR} state_t;

  localparam logic [7:0] REFRACT_L = 8'(REFRACT);

  state_t      r_state;
  logic [15:0] r_vmem;
  logic        r_spike;
  logic        r_refr;
  logic [7:0]  r_count;
  logic [7:0]  r_refr_cnt;

  logic [16:0] w_add;
  logic [15:0] w_sat;
  logic [15:0] w_leak;
  logic        w_fire;

  // Same-cycle current counts toward a coincident step.
  assign w_add  = {1'b0, r_vmem} + {1'b0, (cur_valid ? cur : 16'd0)};
  assign w_sat  = w_add[16] ? 16'hFFFF : w_add[15:0];
  assign w_leak = w_sat - (w_sat >> LEAK_SHIFT);
  assign w_fire = (w_sat >= THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INTEG;
      r_vmem     <= 16'd0;
      r_spike    <= 1'b0;
      r_refr     <= 1'b0;
      r_count    <= 8'd0;
      r_refr_cnt <= 8'd0;
    end else begin
      r_spike <= 1'b0;
      case (r_state)
        ST_INTEG: begin
          if (step) begin
            if (w_fire) begin
              r_spike <= 1'b1;
              r_vmem  <= 16'd0;
              r_count <= r_count + 8'd1;
              if (REFRACT_L != 8'd0) begin
                r_state    <= ST_REFR;
                r_refr     <= 1'b1;
                r_refr_cnt <= REFRACT_L;
              end
            end else begin
              r_vmem <= w_leak;
            end
          end else if (cur_valid) begin
            r_vmem <= w_sat;
          end
        end
        ST_REFR: begin
          r_vmem <= 16'd0;
          if (step) begin
            if (r_refr_cnt == 8'd1) begin
              r_state    <= ST_INTEG;
              r_refr     <= 1'b0;
              r_refr_cnt <= 8'd0;
            end else begin
              r_refr_cnt <= r_refr_cnt - 8'd1;
            end
          end
        end
        default: r_state <= ST_INTEG;
      endcase
    end
  end

  assign spike       = r_spike;
  assign vmem        = r_vmem;
  assign refr        = r_refr;
  assign spike_count = r_count;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed and random stimulus for lif_neuron (THRESH=100, LEAK_SHIFT=2, REFRACT=2)
// checked against an integer reference model of the neuron.
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cur_valid = 1'b0;
  logic [15:0] cur = 16'd0;
  logic        step = 1'b0;
  logic        spike;
  logic [15:0] vmem;
  logic        refr;
  logic [7:0]  spike_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_v, m_left, m_count, m_spike;

  lif_neuron #(.THRESH(16'd100), .LEAK_SHIFT(2), .REFRACT(2)) dut (
    .clk(clk), .reset(reset), .cur_valid(cur_valid), .cur(cur), .step(step),
    .spike(spike), .vmem(vmem), .refr(refr), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit cv, input int c, input bit s);
    int sum;
    if (r) begin
      m_v = 0; m_left = 0; m_count = 0; m_spike = 0;
      return;
    end
    m_spike = 0;
    if (m_left > 0) begin
      m_v = 0;
      if (s) m_left = m_left - 1;
    end else begin
      sum = m_v + (cv ? c : 0);
      if (sum > 65535) sum = 65535;
      if (s) begin
        if (sum >= 100) begin
          m_spike = 1;
          m_v     = 0;
          m_count = (m_count + 1) % 256;
          m_left  = 2;
        end else begin
          m_v = sum - sum / 4;
        end
      end else begin
        m_v = sum;
      end
    end
  endtask

  task automatic tick(input bit r, input bit cv, input logic [15:0] c, input bit s);
    reset = r; cur_valid = cv; cur = c; step = s;
    @(posedge clk);
    #1;
    model(r, cv, int'(c), s);
    chk("m_spike", 16'(spike), 16'(m_spike));
    chk("m_vmem", vmem, 16'(m_v));
    chk("m_refr", 16'(refr), 16'(m_left > 0));
    chk("m_count", 16'(spike_count), 16'(m_count));
  endtask

  initial begin
    // Reset held two cycles with activity on the inputs
    tick(1, 1, 16'd500, 1);
    chk("rst_spike0", 16'(spike), 16'd0);
    tick(1, 0, 16'd0, 0);
    chk("rst_vmem", vmem, 16'd0);
    chk("rst_spike", 16'(spike), 16'd0);
    chk("rst_refr", 16'(refr), 16'd0);
    chk("rst_count", 16'(spike_count), 16'd0);

    // Integrate then leak
    tick(0, 1, 16'd32, 0); chk("int_32", vmem, 16'd32);
    tick(0, 1, 16'd6, 0);  chk("int_38", vmem, 16'd38);
    tick(0, 1, 16'd2, 0);  chk("int_40", vmem, 16'd40);
    tick(0, 0, 16'd0, 1);  chk("leak_30", vmem, 16'd30);
    chk("leak_nospike", 16'(spike), 16'd0);

    // Fire on coincident current
    tick(0, 1, 16'd70, 1);
    chk("fire_spike", 16'(spike), 16'd1);
    chk("fire_vmem", vmem, 16'd0);
    chk("fire_refr", 16'(refr), 16'd1);
    chk("fire_count", 16'(spike_count), 16'd1);
    tick(0, 0, 16'd0, 0);
    chk("spike_drop", 16'(spike), 16'd0);

    // Refractory: current dropped, two steps to exit
    tick(0, 1, 16'd200, 0); chk("refr_hold", vmem, 16'd0);
    tick(0, 0, 16'd0, 1);   chk("refr_step1", 16'(refr), 16'd1);
    tick(0, 1, 16'd99, 1);  chk("refr_step2", 16'(refr), 16'd0);
    chk("refr_exit_drop", vmem, 16'd0);
    tick(0, 1, 16'd50, 0);  chk("resume_50", vmem, 16'd50);

    // Saturation
    tick(0, 1, 16'hFFFF, 0); chk("sat1", vmem, 16'hFFFF);
    tick(0, 1, 16'hFFFF, 0); chk("sat2", vmem, 16'hFFFF);
    tick(0, 0, 16'd0, 1);
    chk("sat_fire", 16'(spike), 16'd1);
    chk("sat_count", 16'(spike_count), 16'd2);
    tick(0, 0, 16'd0, 1);
    tick(0, 0, 16'd0, 1);
    chk("sat_exit", 16'(refr), 16'd0);

    // Threshold boundary: 99 leaks, 100 fires
    tick(0, 1, 16'd99, 1);
    chk("thr99_nofire", 16'(spike), 16'd0);
    chk("thr99_leak", vmem, 16'd75);
    tick(0, 1, 16'd25, 0);  chk("thr_100", vmem, 16'd100);
    tick(0, 0, 16'd0, 1);
    chk("thr100_fire", 16'(spike), 16'd1);
    chk("thr100_count", 16'(spike_count), 16'd3);

    // Reset mid-refractory with coincident step
    tick(1, 1, 16'd7, 1);
    chk("rstr_refr", 16'(refr), 16'd0);
    chk("rstr_vmem", vmem, 16'd0);
    chk("rstr_count", 16'(spike_count), 16'd0);
    tick(0, 1, 16'd10, 0);  chk("rstr_int10", vmem, 16'd10);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, cv, s;
      logic [15:0] c;
      r  = ($urandom_range(0, 149) == 0);
      cv = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'($urandom_range(0, 60));
      tick(r, cv, c, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron stage sitting directly downstream of the `mac` unit. Each cycle it accepts the MAC's 16-bit output as an input current and integrates it into a membrane potential. On a timestep strobe it either fires a one-cycle spike and enters a refractory period, or applies a shift-based leak. It is the first stateful neuron element of the coprocessor datapath.

## Interface
- `THRESH`, 16'd1000: firing threshold, unsigned; fire when potential >= THRESH.
- `LEAK_SHIFT`, 4: leak amount per timestep is `v >> LEAK_SHIFT`; legal range 1..15.
- `REFRACT`, 3: number of timestep strobes spent refractory after a spike; legal range 0..255.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cur_valid`  in  1  `cur` is valid this cycle.
- `cur`  in  16  unsigned input current, connected to MAC `out`.
- `step`  in  1  timestep strobe, one cycle wide; may coincide with `cur_valid`.
- `spike`  out  1  registered one-cycle spike pulse.
- `vmem`  out  16  registered membrane potential.
- `refr`  out  1  high while in the REFRACTORY state.
- `spike_count`  out  8  spikes since reset; wraps modulo 256.

## Operation
- Reset: `vmem`=0, `spike`=0, `refr`=0, `spike_count`=0, state=INTEGRATE, refractory counter=0.
- Two states: INTEGRATE and REFRACTORY.
- INTEGRATE, `cur_valid`=1, `step`=0:
  - `vmem <= sat16(vmem + cur)`, using a 17-bit add that saturates at 16'hFFFF.
- INTEGRATE, `step`=1:
  - Form `v' = sat16(vmem + (cur_valid ? cur : 0))`. Current arriving in the same cycle counts toward this step.
  - If `v' >= THRESH`: `spike <= 1`, `vmem <= 0`, `spike_count <= spike_count+1`.
  - After a fire, with REFRACT>0: state goes to REFRACTORY and counter is loaded with REFRACT. With REFRACT=0: stay in INTEGRATE.
  - Otherwise: `vmem <= v' - (v' >> LEAK_SHIFT)`. Result never underflows; a value below `1<<LEAK_SHIFT` is unchanged by leak.
- REFRACTORY:
  - `vmem` held at 0. `cur_valid`/`cur` ignored and the current is dropped, not buffered.
  - On each `step`: if counter==1, go to INTEGRATE with counter=0; else decrement the counter.
- `spike` is high for exactly one cycle per fire and deasserts the following cycle unconditionally.
- `refr` equals (state==REFRACTORY), registered.
- No backpressure; the block accepts `cur` every cycle.

## Timing
- `cur_valid` sampled at edge N: updated `vmem` visible after edge N (1-cycle latency).
- `step` sampled at edge N: `spike`, `refr`, `spike_count` and leaked/cleared `vmem` visible after edge N, all in the same cycle.
- Back-to-back `step` strobes are legal; each is a full timestep.
- The step that ends the refractory period sees `refr` drop after that edge. `cur_valid` in that same cycle is still dropped; integration resumes the next cycle.
- `reset` overrides everything in the cycle it is sampled, including mid-refractory and a coincident `step`.

## Test plan
Parameters for all scenarios: THRESH=100, LEAK_SHIFT=2, REFRACT=2.
- Reset: hold `reset` 2 cycles with `step`/`cur_valid` toggling -> all outputs 0; `spike` never asserts.
- Integrate and leak: `cur`=32, 6, 2 valid on consecutive cycles -> `vmem`=32, 38, 40. Then `step` alone -> `vmem`=30, `spike`=0.
- Fire on coincident input: from `vmem`=30, `cur_valid` with `cur`=70 plus `step` in the same cycle -> next cycle `spike`=1, `vmem`=0, `refr`=1, `spike_count`=1. One cycle later `spike`=0.
- Refractory:
  - `cur`=200 valid during `refr` -> `vmem` stays 0.
  - First `step` -> `refr` still 1. Second `step` -> `refr`=0.
  - `cur`=50 on the next cycle -> `vmem`=50.
- Saturation and threshold equality:
  - `cur`=16'hFFFF twice -> `vmem`=16'hFFFF, then `step` fires.
  - Separately, `vmem`=100 exactly on `step` -> fires.
- Reset mid-refractory: assert `reset` while `refr`=1 -> next cycle `refr`=0, `vmem`=0, `spike_count`=0. A subsequent `cur`=10 integrates to `vmem`=10.
